jelly_semaphore_cmd_gate: RTL and testbench

Credit-gated command issuer sitting directly upstream of the semaphore block, on its request side. Accepts one burst command at a time (address plus beat length), waits until the semaphore counter holds enough credits for the whole burst, then pulses a credit-take request and forwards the command downstream. Intended to throttle AXI read-address issue to the free space of a downstream read-data buffer.

---
 rtl/jelly_semaphore_cmd_gate.sv | 171 +++++++++++++++++
 tb/tb_jelly_semaphore_cmd_gate.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_semaphore_cmd_gate.sv
// ----------------------------------------------------------------------------
// jelly_semaphore_cmd_gate
//   Credit-gated burst command issuer placed on the request side of a
//   semaphore. It accepts one command (address + AXI-style length), waits
//   until the semaphore holds credits for the whole burst, pulses a
//   credit-take strobe, and then forwards the command downstream.
//
// Optional feature macro: JELLY_SEMAPHORE_CMD_GATE_STALL_COUNT_EN
//   When defined, stall_count counts cycles spent waiting for credits
//   (saturating, cleared only by reset). When undefined, stall_count is 0.
//
// Ports
//   aresetn      in   async active-low reset
//   aclk         in   clock
//   s_addr       in   upstream command address
//   s_len        in   upstream burst length (beats-1)
//   s_valid      in   upstream command valid
//   s_ready      out  upstream ready (registered)
//   m_addr       out  issued command address (registered)
//   m_len        out  issued burst length (registered)
//   m_valid      out  issued command valid (registered)
//   m_ready      in   downstream ready
//   sem_counter  in   semaphore credit count
//   sem_empty    in   semaphore count is zero
//   sem_sub      out  credits to take, 0 when sem_valid is low
//   sem_valid    out  one-cycle credit-take strobe
//   stall_count  out  credit wait cycle counter
// ----------------------------------------------------------------------------
module jelly_semaphore_cmd_gate #(
  parameter int unsigned COUNTER_WIDTH = 9,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH    = 32
) (
  input  logic                     aresetn,
  input  logic                     aclk,

  input  logic [ADDR_WIDTH-1:0]    s_addr,
  input  logic [LEN_WIDTH-1:0]     s_len,
  input  logic                     s_valid,
  output logic                     s_ready,

  output logic [ADDR_WIDTH-1:0]    m_addr,
  output logic [LEN_WIDTH-1:0]     m_len,
  output logic                     m_valid,
  input  logic                     m_ready,

  input  logic [COUNTER_WIDTH-1:0] sem_counter,
  input  logic                     sem_empty,
  output logic [COUNTER_WIDTH-1:0] sem_sub,
  output logic                     sem_valid,

  output logic [31:0]              stall_count
);

  localparam int unsigned STALL_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [LEN_WIDTH-1:0]     r_len;
  logic [COUNTER_WIDTH-1:0] r_need;
  logic                     r_s_ready;
  logic                     r_m_valid;

  logic                     w_accept;
  logic                     w_credit_ok;
  logic                     w_grant;
  logic                     w_issue_done;
  logic                     w_sem_valid;
  logic [COUNTER_WIDTH-1:0] w_sem_sub;
  logic [COUNTER_WIDTH-1:0] w_need_in;

  // Beat count of the incoming burst; COUNTER_WIDTH > LEN_WIDTH keeps len+1 exact.
  assign w_need_in    = COUNTER_WIDTH'(s_len) + COUNTER_WIDTH'(1);

  assign w_accept     = s_valid && r_s_ready;
  assign w_credit_ok  = !sem_empty && (sem_counter >= r_need);
  assign w_issue_done = r_m_valid && m_ready;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and credit-take strobe. The take is a same-cycle decode of the
  // WAIT state so the semaphore sees it exactly once, on the granting cycle.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_sem_valid  = 1'b0;
    w_sem_sub    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_credit_ok) begin
          w_grant      = 1'b1;
          w_sem_valid  = 1'b1;
          w_sem_sub    = r_need;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_issue_done) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Command latch and registered handshake flags derived from the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_need    <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= s_addr;
        r_len  <= s_len;
        r_need <= w_need_in;
      end
      r_s_ready <= (w_next_state == ST_IDLE);
      r_m_valid <= (w_next_state == ST_ISSUE);
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_addr    = r_addr;
  assign m_len     = r_len;
  assign sem_valid = w_sem_valid;
  assign sem_sub   = w_sem_sub;

`ifdef JELLY_SEMAPHORE_CMD_GATE_STALL_COUNT_EN
  logic [STALL_WIDTH-1:0] r_stall_count;

  // Saturating count of WAIT cycles that did not grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stall_count <= '0;
    end else if ((r_state == ST_WAIT) && !w_grant && (r_stall_count != {STALL_WIDTH{1'b1}})) begin
      r_stall_count <= r_stall_count + STALL_WIDTH'(1);
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = STALL_WIDTH'(0);
`endif

endmodule

// File: tb/tb_jelly_semaphore_cmd_gate.sv
// ----------------------------------------------------------------------------
// tb_jelly_semaphore_cmd_gate
//   Self-checking bench. The bench plays the semaphore (credit pool that loses
//   the taken amount on the edge after a take) and holds a transaction-level
//   expectation: a burst of len+1 beats is granted on the first WAIT cycle the
//   pool holds at least that many credits, then issued until m_ready.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jelly_semaphore_cmd_gate;

  localparam int CW = 9;
  localparam int LW = 8;
  localparam int AW = 32;
  localparam int CREDIT_MAX = (1 << CW) - 1;

  logic          aresetn;
  logic          aclk;
  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_len;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] sem_counter;
  logic          sem_empty;
  logic [CW-1:0] sem_sub;
  logic          sem_valid;
  logic [31:0]   stall_count;

  jelly_semaphore_cmd_gate #(
    .COUNTER_WIDTH (CW),
    .LEN_WIDTH     (LW),
    .ADDR_WIDTH    (AW)
  ) dut (
    .aresetn     (aresetn),
    .aclk        (aclk),
    .s_addr      (s_addr),
    .s_len       (s_len),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_addr      (m_addr),
    .m_len       (m_len),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .sem_counter (sem_counter),
    .sem_empty   (sem_empty),
    .sem_sub     (sem_sub),
    .sem_valid   (sem_valid),
    .stall_count (stall_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Semaphore model state
  int credit    = 0;
  int take_amt  = 0;
  int add_amt   = 0;
  // Expected number of non-granting wait cycles since reset
  longint exp_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_stall_count();
`ifdef JELLY_SEMAPHORE_CMD_GATE_STALL_COUNT_EN
    return (exp_stall > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(exp_stall);
`else
    return 64'd0;
`endif
  endfunction

  task automatic drive_credit();
    sem_counter = CW'(credit);
    sem_empty   = (credit == 0);
  endtask

  task automatic set_credit(input int c);
    credit = c;
    drive_credit();
  endtask

  // One clock: semaphore absorbs take/add on the edge, inputs settle, then check point.
  task automatic step();
    @(posedge aclk);
    #1;
    credit = credit - take_amt + add_amt;
    if (credit > CREDIT_MAX) credit = CREDIT_MAX;
    if (credit < 0) credit = 0;
    take_amt = 0;
    add_amt  = 0;
    drive_credit();
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_s_ready"},   64'(s_ready),     64'd0);
    chk({tag, "_m_valid"},   64'(m_valid),     64'd0);
    chk({tag, "_m_addr"},    64'(m_addr),      64'd0);
    chk({tag, "_m_len"},     64'(m_len),       64'd0);
    chk({tag, "_sem_valid"}, 64'(sem_valid),   64'd0);
    chk({tag, "_sem_sub"},   64'(sem_sub),     64'd0);
    chk({tag, "_stall"},     64'(stall_count), 64'd0);
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    take_amt = 0;
    add_amt  = 0;
    set_credit(0);
    exp_stall = 0;
  endtask

  task automatic release_reset();
    aresetn = 1'b1;
    step();
    chk("post_reset_s_ready", 64'(s_ready), 64'd1);
  endtask

  // Full command: stall_target = non-granting cycles before the bench tops the
  // pool up to exactly the need; rnd_adds sprinkles extra credits while waiting.
  task automatic run_cmd(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input int stall_target, input int ready_stall, input bit rnd_adds);
    int  need;
    int  stalled;
    bit  granted;
    bit  exp_grant;
    need    = int'(l) + 1;
    stalled = 0;
    granted = 1'b0;

    chk({tag, "_idle_s_ready"},   64'(s_ready),     64'd1);
    chk({tag, "_idle_m_valid"},   64'(m_valid),     64'd0);
    chk({tag, "_idle_sem_valid"}, 64'(sem_valid),   64'd0);
    chk({tag, "_idle_stall"},     64'(stall_count), exp_stall_count());

    s_addr  = a;
    s_len   = l;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_addr  = $urandom;
    s_len   = LW'($urandom);

    for (int cyc = 0; cyc < 400 && !granted; cyc++) begin
      exp_grant = (credit != 0) && (credit >= need);
      chk({tag, "_wait_sem_valid"}, 64'(sem_valid), 64'(exp_grant));
      chk({tag, "_wait_sem_sub"},   64'(sem_sub),   exp_grant ? 64'(need) : 64'd0);
      chk({tag, "_wait_s_ready"},   64'(s_ready),   64'd0);
      chk({tag, "_wait_m_valid"},   64'(m_valid),   64'd0);
      if (exp_grant) begin
        granted  = 1'b1;
        take_amt = need;
      end else begin
        stalled++;
        exp_stall++;
        if (stalled >= stall_target) add_amt = need - credit;
        else if (rnd_adds && ($urandom_range(0, 3) == 0)) add_amt = int'($urandom_range(0, 3));
      end
      step();
    end
    n_checks++;
    assert (granted) else begin
      n_errors++;
      $error("FAIL %s_grant_timeout: observed=no_grant expected=grant", tag);
    end

    for (int k = 0; k <= ready_stall; k++) begin
      m_ready = (k == ready_stall);
      chk({tag, "_issue_m_valid"},   64'(m_valid),   64'd1);
      chk({tag, "_issue_m_addr"},    64'(m_addr),    64'(a));
      chk({tag, "_issue_m_len"},     64'(m_len),     64'(l));
      chk({tag, "_issue_s_ready"},   64'(s_ready),   64'd0);
      chk({tag, "_issue_sem_valid"}, 64'(sem_valid), 64'd0);
      chk({tag, "_issue_sem_sub"},   64'(sem_sub),   64'd0);
      step();
    end
    m_ready = 1'b0;
    chk({tag, "_done_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_done_s_ready"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    s_addr  = '0;
    s_len   = '0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    apply_reset();
    #1;
    chk_reset_values("in_reset");
    repeat (2) @(posedge aclk);
    #2;
    release_reset();

    // Plenty of credits: grant first WAIT cycle, issue next.
    set_credit(256);
    run_cmd("basic", 32'h1000_0040, 8'd15, 0, 0, 1'b0);
    chk("basic_credit_after", 64'(sem_counter), 64'd240);

    // Insufficient credits, then exactly enough.
    set_credit(10);
    run_cmd("low_credit", 32'hDEAD_BEE0, 8'd15, 3, 0, 1'b0);

    // Empty semaphore, single beat.
    set_credit(0);
    run_cmd("empty", 32'h0000_0004, 8'd0, 2, 0, 1'b0);

    // Maximum burst needs 256 credits, no truncation.
    set_credit(256);
    run_cmd("max_len", 32'hFFFF_FF00, 8'd255, 0, 0, 1'b0);
    chk("max_len_credit_after", 64'(sem_counter), 64'd0);

    // Downstream back-pressure for 5 cycles.
    set_credit(100);
    run_cmd("backpressure", 32'h1234_5678, 8'd7, 0, 5, 1'b0);

    // Reset while waiting for credits.
    set_credit(0);
    s_addr = 32'hCAFE_0000; s_len = 8'd3; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    exp_stall++;
    step();
    exp_stall++;
    step();
    chk("wait_pre_reset_sem_valid", 64'(sem_valid), 64'd0);
    apply_reset();
    #1;
    chk_reset_values("rst_wait");
    #3;
    release_reset();

    // Reset while issuing.
    set_credit(50);
    s_addr = 32'hBEEF_0100; s_len = 8'd4; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("issue_pre_reset_take", 64'(sem_valid), 64'd1);
    take_amt = 5;
    step();
    chk("issue_pre_reset_m_valid", 64'(m_valid), 64'd1);
    chk("issue_pre_reset_m_addr",  64'(m_addr),  64'hBEEF_0100);
    apply_reset();
    #1;
    chk_reset_values("rst_issue");
    #3;
    release_reset();

    // Exactly four stalled cycles before grant.
    set_credit(0);
    run_cmd("stall4", 32'h0000_8000, 8'd1, 4, 0, 1'b0);
    chk("stall4_count", 64'(stall_count), exp_stall_count());

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      logic [LW-1:0] l;
      l = ($urandom_range(0, 7) == 0) ? LW'($urandom) : LW'($urandom_range(0, 31));
      set_credit(int'($urandom_range(0, 60)));
      run_cmd("rand", $urandom, l, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b1);
    end
    chk("final_stall", 64'(stall_count), exp_stall_count());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
